// File: rtl/fir_sram_seq_if.sv
// Bundle between the FIR input sequencer and the sample SRAM / MAC side:
// sample handshake, SRAM write/read ports and the beat sideband.
interface fir_sram_seq_if;
   logic             in_valid;
   logic [19:0]      in_data;
   logic             in_ready;
   logic [19:0]      D;
   logic [10:0]      CADDR;
   logic             WEN;
   logic             CEN;
   logic [7:0][7:0]  A;
   logic             beat_vld;
   logic [7:0]       beat_idx;
   logic             beat_first;
   logic             beat_last;
   logic [2:0]       rot;
   logic             busy;

   modport master (
      input  in_valid, in_data,
      output in_ready, D, CADDR, WEN, CEN, A,
             beat_vld, beat_idx, beat_first, beat_last, rot, busy
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, D, CADDR, WEN, CEN, A,
             beat_vld, beat_idx, beat_first, beat_last, rot, busy
   );
endinterface

// File: rtl/fir_sram_seq.sv
// Input sequencer for the 8-bank sample store: clears the store, writes each
// accepted sample into a circular history and issues the NTAPS/8 read beats.
module fir_sram_seq #(
   parameter int NTAPS  = 64,
   parameter int RD_LAT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   fir_sram_seq_if.master bus
);
   localparam int          NBEATS    = NTAPS / 8;
   localparam logic [7:0]  LAST_BEAT = 8'(NBEATS - 1);
   localparam logic [10:0] CLR_LAST  = 11'd2047;

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_WRITE = 2'd2,
      S_READ  = 2'd3
   } state_t;

   typedef logic [7:0][7:0] rows_t;

   typedef struct packed {
      logic       vld;
      logic [7:0] idx;
      logic       first;
      logic       last;
      logic [2:0] rot;
   } sb_t;

   state_t      r_state;
   logic [10:0] r_clr;
   logic [10:0] r_wp;
   logic [10:0] r_w;
   logic [7:0]  r_row;
   logic [7:0]  r_beat;
   logic        r_cen;
   logic        r_wen;
   logic [19:0] r_d;
   logic [10:0] r_caddr;
   rows_t       r_a;
   logic        r_in_ready;
   logic        r_busy;
   sb_t         r_sb0;
   sb_t         r_sb [RD_LAT];

   logic        w_accept;
   logic [7:0]  w_row_next;
   logic [7:0]  w_beat_next;

   // Banks above w[2:0] hold their taps one row earlier: the 8-sample window
   // of a beat straddles a row boundary unless it ends in bank 7.
   function automatic rows_t f_bank_rows(input logic [7:0] row, input logic [2:0] w_lo);
      rows_t rows;
      for (int m = 0; m < 8; m++) begin
         if (3'(m) > w_lo) begin
            rows[m] = row - 8'd1;
         end else begin
            rows[m] = row;
         end
      end
      return rows;
   endfunction

   assign w_accept    = r_in_ready && bus.in_valid;
   assign w_row_next  = r_row - 8'd1;
   assign w_beat_next = r_beat + 8'd1;

   // Sequencer FSM; every SRAM and handshake output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_CLEAR;
         r_clr      <= 11'd0;
         r_wp       <= 11'd0;
         r_w        <= 11'd0;
         r_row      <= 8'd0;
         r_beat     <= 8'd0;
         r_cen      <= 1'b1;
         r_wen      <= 1'b1;
         r_d        <= 20'd0;
         r_caddr    <= 11'd0;
         r_a        <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b1;
         r_sb0      <= '0;
      end else begin
         r_sb0.vld <= 1'b0;
         case (r_state)
            S_CLEAR: begin
               r_cen   <= 1'b0;
               r_wen   <= 1'b0;
               r_d     <= 20'd0;
               r_caddr <= r_clr;
               r_clr   <= r_clr + 11'd1;
               if (r_clr == CLR_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_CLEAR;
               end
            end
            S_IDLE: begin
               if (w_accept) begin
                  r_w        <= r_wp;
                  r_d        <= bus.in_data;
                  r_caddr    <= {r_wp[2:0], r_wp[10:3]};
                  r_cen      <= 1'b0;
                  r_wen      <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_WRITE;
               end else begin
                  r_cen      <= 1'b1;
                  r_wen      <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            S_WRITE: begin
               r_wp        <= r_wp + 11'd1;
               r_cen       <= 1'b0;
               r_wen       <= 1'b1;
               r_beat      <= 8'd0;
               r_row       <= r_w[10:3];
               r_a         <= f_bank_rows(r_w[10:3], r_w[2:0]);
               r_sb0.vld   <= 1'b1;
               r_sb0.idx   <= 8'd0;
               r_sb0.first <= 1'b1;
               r_sb0.last  <= (LAST_BEAT == 8'd0);
               r_sb0.rot   <= r_w[2:0];
               r_state     <= S_READ;
            end
            S_READ: begin
               if (r_beat == LAST_BEAT) begin
                  r_cen      <= 1'b1;
                  r_wen      <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_cen       <= 1'b0;
                  r_wen       <= 1'b1;
                  r_beat      <= w_beat_next;
                  r_row       <= w_row_next;
                  r_a         <= f_bank_rows(w_row_next, r_w[2:0]);
                  r_sb0.vld   <= 1'b1;
                  r_sb0.idx   <= w_beat_next;
                  r_sb0.first <= 1'b0;
                  r_sb0.last  <= (w_beat_next == LAST_BEAT);
                  r_sb0.rot   <= r_w[2:0];
                  r_state     <= S_READ;
               end
            end
            default: begin
               r_cen      <= 1'b1;
               r_wen      <= 1'b1;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b1;
               r_clr      <= 11'd0;
               r_state    <= S_CLEAR;
            end
         endcase
      end
   end

   // Sideband delay line so each beat's tags line up with its SRAM Q data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_sb[i] <= '0;
         end
      end else begin
         r_sb[0] <= r_sb0;
         for (int i = 1; i < RD_LAT; i++) begin
            r_sb[i] <= r_sb[i-1];
         end
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.D          = r_d;
   assign bus.CADDR      = r_caddr;
   assign bus.WEN        = r_wen;
   assign bus.CEN        = r_cen;
   assign bus.A          = r_a;
   assign bus.busy       = r_busy;
   assign bus.beat_vld   = r_sb[RD_LAT-1].vld;
   assign bus.beat_idx   = r_sb[RD_LAT-1].idx;
   assign bus.beat_first = r_sb[RD_LAT-1].first;
   assign bus.beat_last  = r_sb[RD_LAT-1].last;
   assign bus.rot        = r_sb[RD_LAT-1].rot;
endmodule
